// File: rtl/rom_reader_pkg.sv
// Package: rom_reader_pkg
// Shared types and constants for the ROM stream reader.
//   state_t    : burst sequencer state (IDLE, RUN, DRAIN)
//   FIFO_DEPTH : number of entries in the output buffer
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_reader_fifo2.sv
// Module: rom_reader_fifo2
// Two-entry first-word-fall-through FIFO used as the stream output buffer.
// The head entry is visible on dout whenever the FIFO is not empty.
// Ports:
//   CLK    in   clock
//   RESET  in   synchronous active-high reset (empties FIFO, clears storage)
//   push   in   write din this cycle (caller guarantees !full or a same-cycle pop)
//   din    in   write data
//   pop    in   remove head this cycle (caller guarantees !empty)
//   dout   out  head entry
//   empty  out  no entries held
//   full   out  both entries held
module rom_reader_fifo2
    import rom_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Push and pop together leave occupancy unchanged, including when full.
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign empty = (r_count == 2'd0);
    assign full  = (r_count == 2'd2);

endmodule

// File: rtl/rom_stream_reader.sv
// Module: rom_stream_reader
// Address sequencer and output buffer around a combinational-read ROM. On START it walks
// RADDR through LEN consecutive words from BASE (wrapping modulo DEPTH), captures RDATA into a
// 2-entry FWFT FIFO and presents it as a valid/ready stream.
// Optional feature macro: ROM_READER_CKSUM_EN adds CKSUM, the XOR of all words popped in the
// current burst (cleared on START acceptance and reset, held after DONE).
// Ports:
//   CLK      in   clock
//   RESET    in   synchronous active-high reset; aborts any burst without DONE
//   START    in   begin burst (IDLE only)
//   BASE     in   first address
//   LEN      in   word count 0..DEPTH
//   RADDR    out  ROM read address
//   RDATA    in   ROM read data (combinational from RADDR)
//   O_DATA   out  stream data
//   O_VALID  out  stream valid
//   O_READY  in   stream ready
//   BUSY     out  high in RUN and DRAIN
//   DONE     out  one-cycle pulse after the final pop
//   CKSUM    out  (ROM_READER_CKSUM_EN only) running XOR of popped words
module rom_stream_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [AW-1:0]    BASE,
    input  logic [AW:0]      LEN,
    output logic [AW-1:0]    RADDR,
    input  logic [WIDTH-1:0] RDATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             BUSY,
`ifdef ROM_READER_CKSUM_EN
    output logic             DONE,
    output logic [WIDTH-1:0] CKSUM
`else
    output logic             DONE
`endif
);

    localparam logic [AW:0] LAST_CNT = (AW + 1)'(1);

    state_t        r_state;
    logic [AW-1:0] r_raddr;
    logic [AW:0]   r_issue_cnt;
    logic [AW:0]   r_drain_cnt;
    logic          r_busy;
    logic          r_done;

    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = O_VALID & O_READY;
    // A same-cycle pop frees a slot, so a full FIFO can still accept a word.
    assign w_push = (r_state == RUN) && (!w_fifo_full || w_pop);

    rom_reader_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (w_push),
        .din   (RDATA),
        .pop   (w_pop),
        .dout  (O_DATA),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_raddr     <= '0;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        if (LEN != '0) begin
                            r_state     <= RUN;
                            r_raddr     <= BASE;
                            r_issue_cnt <= LEN;
                            r_drain_cnt <= LEN;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_raddr     <= r_raddr + AW'(1);
                        r_issue_cnt <= r_issue_cnt - LAST_CNT;
                        if (r_issue_cnt == LAST_CNT) begin
                            r_state <= DRAIN;
                        end
                    end
                    // The last word is always pushed before it can be popped, so the
                    // final pop can only happen in DRAIN.
                    if (w_pop) begin
                        r_drain_cnt <= r_drain_cnt - LAST_CNT;
                    end
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_drain_cnt <= r_drain_cnt - LAST_CNT;
                        if (r_drain_cnt == LAST_CNT) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RADDR   = r_raddr;
    assign O_VALID = ~w_fifo_empty;
    assign BUSY    = r_busy;
    assign DONE    = r_done;

`ifdef ROM_READER_CKSUM_EN
    logic [WIDTH-1:0] r_cksum;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cksum <= '0;
        end else if (r_state == IDLE && START) begin
            r_cksum <= '0;
        end else if (w_pop) begin
            r_cksum <= r_cksum ^ O_DATA;
        end
    end

    assign CKSUM = r_cksum;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with DEPTH=4, WIDTH=5, ROM = 5,0,21,11.
module tb_rom_stream_reader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 5;
    localparam int unsigned AW    = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [AW-1:0]    base;
    logic [AW:0]      len;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_ready;
    logic             busy;
    logic             done;
`ifdef ROM_READER_CKSUM_EN
    logic [WIDTH-1:0] cksum;
`endif

    logic [WIDTH-1:0] rom [DEPTH];
    assign rdata = rom[raddr];

    int checks = 0;
    int errors = 0;

    rom_stream_reader #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .CLK     (clk),
        .RESET   (reset),
        .START   (start),
        .BASE    (base),
        .LEN     (len),
        .RADDR   (raddr),
        .RDATA   (rdata),
        .O_DATA  (o_data),
        .O_VALID (o_valid),
        .O_READY (o_ready),
        .BUSY    (busy),
`ifdef ROM_READER_CKSUM_EN
        .DONE    (done),
        .CKSUM   (cksum)
`else
        .DONE    (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b done=%b required 0 0 0",
                     o_valid, busy, done);
        end
        checks++;
        if (raddr !== 2'd0 || o_data !== 5'd0) begin
            errors++;
            $display("FAIL reset_values: raddr=%0d data=%0d required 0 0", raddr, o_data);
        end
    endtask

    task automatic test_full_burst();
        logic [WIDTH-1:0] exp [4];
        exp[0] = 5'd5; exp[1] = 5'd0; exp[2] = 5'd21; exp[3] = 5'd11;
        o_ready = 1'b1;
        issue_start(2'd0, 3'd4);
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_latency: valid=%b busy=%b required 0 1", o_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[i] || done !== 1'b0) begin
                errors++;
                $display("FAIL burst_word%0d: valid=%b data=%0d done=%b required 1 %0d 0",
                         i, o_valid, o_data, done, exp[i]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_done: done=%b busy=%b valid=%b required 1 0 0",
                     done, busy, o_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL burst_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp [3];
        exp[0] = 5'd11; exp[1] = 5'd5; exp[2] = 5'd0;
        o_ready = 1'b1;
        issue_start(2'd3, 3'd3);
        checks++;
        if (raddr !== 2'd3) begin
            errors++;
            $display("FAIL wrap_base: raddr=%0d required 3", raddr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (raddr !== 2'd0) begin
                    errors++;
                    $display("FAIL wrap_raddr: raddr=%0d required 0", raddr);
                end
            end
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp[i]) begin
                errors++;
                $display("FAIL wrap_word%0d: valid=%b data=%0d required 1 %0d",
                         i, o_valid, o_data, exp[i]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: done=%b required 1", done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp [4];
        logic [WIDTH-1:0] got [$];
        logic             finished;
        exp[0] = 5'd0; exp[1] = 5'd21; exp[2] = 5'd11; exp[3] = 5'd5;
        o_ready = 1'b0;
        issue_start(2'd1, 3'd4);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_data !== 5'd0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b data=%0d required 1 0",
                         k, o_valid, o_data);
            end
        end
        checks++;
        if (raddr !== 2'd3) begin
            errors++;
            $display("FAIL stall_raddr: raddr=%0d required 3", raddr);
        end
        o_ready  = 1'b1;
        finished = 1'b0;
        for (int c = 0; c < 20 && !finished; c++) begin
            if (o_valid) got.push_back(o_data);
            tick();
            if (done) finished = 1'b1;
        end
        checks++;
        if (!finished || got.size() != 4) begin
            errors++;
            $display("FAIL stall_count: finished=%b words=%0d required 1 4", finished, got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL stall_word%0d: data=%0d required %0d", i, got[i], exp[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_len_zero();
        o_ready = 1'b1;
        issue_start(2'd2, 3'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: done=%b busy=%b valid=%b required 1 0 0",
                     done, busy, o_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_after: done=%b busy=%b valid=%b required 0 0 0",
                     done, busy, o_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        int done_seen;
        o_ready = 1'b1;
        issue_start(2'd0, 3'd4);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || raddr !== 2'd0) begin
            errors++;
            $display("FAIL abort_state: valid=%b busy=%b done=%b raddr=%0d required 0 0 0 0",
                     o_valid, busy, done, raddr);
        end
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || o_valid) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: activity_cycles=%0d required 0", done_seen);
        end
        issue_start(2'd2, 3'd1);
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 5'd21) begin
            errors++;
            $display("FAIL abort_restart: valid=%b data=%0d required 1 21", o_valid, o_data);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_done: done=%b required 1", done);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        logic [WIDTH-1:0] exp [4];
        logic [WIDTH-1:0] got [$];
        int               done_cnt;
        exp[0] = 5'd5; exp[1] = 5'd0; exp[2] = 5'd21; exp[3] = 5'd11;
        o_ready = 1'b1;
        issue_start(2'd0, 3'd4);
        // Attempt to restart with a different burst while RUN is active.
        start = 1'b1;
        base  = 2'd2;
        len   = 3'd1;
        done_cnt = 0;
        for (int c = 0; c < 20 && done_cnt == 0; c++) begin
            if (o_valid) got.push_back(o_data);
            tick();
            start = 1'b0;
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1 || got.size() != 4) begin
            errors++;
            $display("FAIL busy_start_count: dones=%0d words=%0d required 1 4",
                     done_cnt, got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL busy_start_word%0d: data=%0d required %0d", i, got[i], exp[i]);
                end
            end
        end
`ifdef ROM_READER_CKSUM_EN
        checks++;
        if (cksum !== 5'd27) begin
            errors++;
            $display("FAIL cksum_done: cksum=%0d required 27", cksum);
        end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_after: done=%b busy=%b required 0 0", done, busy);
        end
`ifdef ROM_READER_CKSUM_EN
        checks++;
        if (cksum !== 5'd27) begin
            errors++;
            $display("FAIL cksum_hold: cksum=%0d required 27", cksum);
        end
`endif
    endtask

    initial begin
        rom[0] = 5'd5;
        rom[1] = 5'd0;
        rom[2] = 5'd21;
        rom[3] = 5'd11;
        reset   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        o_ready = 1'b0;
        test_reset();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_reset_mid_burst();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
